// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, signed result out,
// with valid/ready handshakes on both sides.
interface seq_alu_if #(parameter int WIDTH = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           sel;
  logic [WIDTH-1:0]     num1;
  logic [WIDTH-1:0]     num2;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     rem;
  logic                 err;

  modport master (
    output in_valid, sel, num1, num2, out_ready,
    input  in_ready, out_valid, result, rem, err
  );

  modport slave (
    input  in_valid, sel, num1, num2, out_ready,
    output in_ready, out_valid, result, rem, err
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential signed ALU: single-cycle add/sub, bit-serial multiply and restoring divide.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise sel=3 returns err=1.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      reset,
  seq_alu_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  logic [1:0]         state;
  logic [1:0]         op;
  logic               neg;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   rem_q;
  logic               err_q;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] acc_next;
  logic               last;

  // Magnitudes are unsigned, so the most-negative operand maps cleanly to 2^(WIDTH-1).
  always_comb begin
    abs_a    = bus.num1[WIDTH-1] ? -bus.num1 : bus.num1;
    abs_b    = bus.num2[WIDTH-1] ? -bus.num2 : bus.num2;
    ext_a    = {{WIDTH{bus.num1[WIDTH-1]}}, bus.num1};
    ext_b    = {{WIDTH{bus.num2[WIDTH-1]}}, bus.num2};
    acc_next = mag_b[0] ? acc + mcand : acc;
    last     = (cnt == 6'(WIDTH - 1));
  end

`ifdef SEQ_ALU_DIV_EN
  logic               rsign;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   prem;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   prem_next;
  logic [2*WIDTH-1:0] quo_ext;

  // One restoring step: the partial remainder is always below the divisor magnitude.
  always_comb begin
    shifted   = {prem, quo[WIDTH-1]};
    ge        = (shifted >= {1'b0, mag_b});
    diff      = shifted[WIDTH-1:0] - mag_b;
    quo_next  = {quo[WIDTH-2:0], ge};
    prem_next = ge ? diff : shifted[WIDTH-1:0];
    quo_ext   = {{WIDTH{1'b0}}, quo_next};
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op       <= OP_ADD;
      neg      <= 1'b0;
      cnt      <= '0;
      mag_b    <= '0;
      acc      <= '0;
      mcand    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      rsign    <= 1'b0;
      quo      <= '0;
      prem     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op    <= bus.sel;
            neg   <= bus.num1[WIDTH-1] ^ bus.num2[WIDTH-1];
            cnt   <= '0;
            mag_b <= abs_b;
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, abs_a};
`ifdef SEQ_ALU_DIV_EN
            rsign <= bus.num1[WIDTH-1];
            quo   <= abs_a;
            prem  <= '0;
`endif
            case (bus.sel)
              OP_ADD: begin
                result_q <= ext_a + ext_b;
                rem_q    <= '0;
                err_q    <= 1'b0;
                state    <= DONE;
              end
              OP_SUB: begin
                result_q <= ext_a - ext_b;
                rem_q    <= '0;
                err_q    <= 1'b0;
                state    <= DONE;
              end
              OP_MUL: state <= CALC;
              default: begin
`ifdef SEQ_ALU_DIV_EN
                if (bus.num2 == '0) begin
                  result_q <= '1;
                  rem_q    <= bus.num1;
                  err_q    <= 1'b1;
                  state    <= DONE;
                end else begin
                  state <= CALC;
                end
`else
                result_q <= '0;
                rem_q    <= '0;
                err_q    <= 1'b1;
                state    <= DONE;
`endif
              end
            endcase
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (op == OP_MUL) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mag_b <= mag_b >> 1;
            if (last) begin
              result_q <= neg ? -acc_next : acc_next;
              rem_q    <= '0;
              err_q    <= 1'b0;
              state    <= DONE;
            end
          end
`ifdef SEQ_ALU_DIV_EN
          else begin
            quo  <= quo_next;
            prem <= prem_next;
            if (last) begin
              result_q <= neg ? -quo_ext : quo_ext;
              rem_q    <= rsign ? -prem_next : prem_next;
              err_q    <= 1'b0;
              state    <= DONE;
            end
          end
`endif
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.rem       = rem_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed vectors against an arithmetic
// reference model, with one compare process watching every output-valid cycle.
module tb_seq_alu;
  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] res;
    logic [W-1:0]   rem;
    logic           err;
    int             lat;
    int             acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic prev_ov = 1'b0;
  exp_t expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the signed-integer definition of each opcode.
  function automatic void model(input logic [1:0] s, input logic [W-1:0] a,
                                input logic [W-1:0] b, output exp_t e);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    e.rem = '0;
    e.err = 1'b0;
    e.lat = 1;
    e.acc_cyc = 0;
    case (s)
      2'd0: r = sa + sb;
      2'd1: r = sa - sb;
      2'd2: begin r = sa * sb; e.lat = W + 1; end
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (sb == 0) begin
          r = -1;
          e.rem = a;
          e.err = 1'b1;
        end else begin
          r = sa / sb;
          e.rem = W'(sa % sb);
          e.lat = W + 1;
        end
`else
        r = 0;
        e.err = 1'b1;
`endif
      end
    endcase
    e.res = (2*W)'(r);
  endfunction

  task automatic checkModel(input string name, input logic [1:0] s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [2*W-1:0] res,
                            input logic [W-1:0] rem, input logic err, input int lat);
    exp_t e;
    model(s, a, b, e);
    checkOutput({name, " model result"}, 64'(e.res), 64'(res));
    checkOutput({name, " model rem"}, 64'(e.rem), 64'(rem));
    checkOutput({name, " model err"}, 64'(e.err), 64'(err));
    checkOutput({name, " model latency"}, 64'(e.lat), 64'(lat));
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready wait timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.sel  = s;
    bus.num1 = a;
    bus.num2 = b;
    @(posedge clk);
    #1;
    model(s, a, b, e);
    e.acc_cyc = cyc;
    expq.push_back(e);
    bus.in_valid = 1'b0;
    bus.sel  = 2'($urandom);
    bus.num1 = W'($urandom);
    bus.num2 = W'($urandom);
  endtask

  task automatic waitDone();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      checkOutput("completion timeout", 64'(expq.size()), 64'd0);
      expq.delete();
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] res,
                       input logic [W-1:0] rem, input logic err, input int lat);
    checkModel(name, s, a, b, res, rem, err, lat);
    applyStimulus(s, a, b);
    waitDone();
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
    checkOutput({name, " out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({name, " result"}, 64'(bus.result), 64'd0);
    checkOutput({name, " rem"}, 64'(bus.rem), 64'd0);
    checkOutput({name, " err"}, 64'(bus.err), 64'd0);
  endtask

  // Every valid cycle is compared to the head of the queue, so held outputs are rechecked each cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          checkOutput("result", 64'(bus.result), 64'(expq[0].res));
          checkOutput("rem", 64'(bus.rem), 64'(expq[0].rem));
          checkOutput("err", 64'(bus.err), 64'(expq[0].err));
          if (!prev_ov)
            checkOutput("latency", 64'(cyc - expq[0].acc_cyc + 1), 64'(expq[0].lat));
          if (bus.out_ready) void'(expq.pop_front());
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  initial begin
    #2000000;
    fails++;
    $display("[TB] FAIL global timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [1:0]   rs;
    logic [W-1:0] ra, rb;
    int           n;

    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.sel  = 2'd0;
    bus.num1 = '0;
    bus.num2 = '0;
    #12;
    checkResetState("power-on reset");
    @(negedge clk);
    reset = 1'b0;

    runOp("add 80+01", 2'd0, 8'h80, 8'h01, 16'hFF81, 8'h00, 1'b0, 1);
    runOp("sub 80-01", 2'd1, 8'h80, 8'h01, 16'hFF7F, 8'h00, 1'b0, 1);
    runOp("mul 80*80", 2'd2, 8'h80, 8'h80, 16'h4000, 8'h00, 1'b0, 9);
    runOp("mul 80*01", 2'd2, 8'h80, 8'h01, 16'hFF80, 8'h00, 1'b0, 9);
    runOp("add 7F+7F", 2'd0, 8'h7F, 8'h7F, 16'h00FE, 8'h00, 1'b0, 1);
    runOp("mul FF*FF", 2'd2, 8'hFF, 8'hFF, 16'h0001, 8'h00, 1'b0, 9);
`ifdef SEQ_ALU_DIV_EN
    runOp("div 80/02", 2'd3, 8'h80, 8'h02, 16'hFFC0, 8'h00, 1'b0, 9);
    runOp("div 07/FE", 2'd3, 8'h07, 8'hFE, 16'hFFFD, 8'h01, 1'b0, 9);
    runOp("div 80/FF", 2'd3, 8'h80, 8'hFF, 16'h0080, 8'h00, 1'b0, 9);
    runOp("div F9/02", 2'd3, 8'hF9, 8'h02, 16'hFFFD, 8'hFF, 1'b0, 9);
    runOp("div 05/00", 2'd3, 8'h05, 8'h00, 16'hFFFF, 8'h05, 1'b1, 1);
`else
    runOp("div 05/00 off", 2'd3, 8'h05, 8'h00, 16'h0000, 8'h00, 1'b1, 1);
    runOp("div 07/FE off", 2'd3, 8'h07, 8'hFE, 16'h0000, 8'h00, 1'b1, 1);
`endif

    // A spread of operand patterns checked against the model only.
    for (int i = 0; i < 24; i++) begin
      rs = 2'(i % 4);
      ra = W'($urandom);
      rb = (i % 8 == 7) ? '0 : W'($urandom);
      applyStimulus(rs, ra, rb);
      waitDone();
    end

    // Backpressure: result held while out_ready is low, new requests ignored.
    checkModel("bp add", 2'd0, 8'h7F, 8'h01, 16'h0080, 8'h00, 1'b0, 1);
    bus.out_ready = 1'b0;
    applyStimulus(2'd0, 8'h7F, 8'h01);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp out_valid rise", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.sel  = 2'd1;
      bus.num1 = 8'h11;
      bus.num2 = 8'h22;
      checkOutput("bp in_ready held low", 64'(bus.in_ready), 64'd0);
      checkOutput("bp out_valid held", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp in_ready after release", 64'(bus.in_ready), 64'd1);
    checkOutput("bp out_valid after release", 64'(bus.out_valid), 64'd0);
    waitDone();
    repeat (4) @(negedge clk);

    // Reset three cycles into a multiply must abort it silently.
    applyStimulus(2'd2, 8'h55, 8'h33);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    expq.delete();
    #1;
    checkResetState("mid-op async reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    runOp("add 01+01 after reset", 2'd0, 8'h01, 8'h01, 16'h0002, 8'h00, 1'b0, 1);
    runOp("mul 03*FD after reset", 2'd2, 8'h03, 8'hFD, 16'hFFF7, 8'h00, 1'b0, 9);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
